// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the off-chip async SRAM arbiter.
package sram_arb_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  typedef logic [ADDR_W-1:0] sram_addr_t;
  typedef logic [DATA_W-1:0] sram_data_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after the pointer wins.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] gidx
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter owning all async SRAM pins, one access at a time.
// Optional SRAM_ARB_VGA_PRIO_EN: requester 0 wins whenever it requests, pointer untouched.
//
// state  | meaning
// IDLE   | sample req, grant winner, latch its fields
// ACCESS | ACC_CYCLES cycles with ce_b low, read or write strobes
// DONE   | strobes inactive, bus released, done[grant] pulses
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int ACC_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ-1:0]             req_we,
  input  logic [NREQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NREQ-1:0][DATA_W-1:0] req_wdata,
  input  logic [NREQ-1:0][1:0]        req_be,
  output logic [NREQ-1:0]             done,
  output sram_data_t                  rdata,
  output sram_addr_t                  sram_addr,
  inout  wire  [DATA_W-1:0]           sram_io,
  output logic                        sram_ce_b,
  output logic                        sram_oe_b,
  output logic                        sram_we_b,
  output logic                        sram_ub_b,
  output logic                        sram_lb_b
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(ACC_CYCLES + 1);
  localparam logic [CW-1:0] LAST     = CW'(ACC_CYCLES);
  localparam logic [CW-1:0] WE_FIRST = CW'(2);
  localparam logic [CW-1:0] WE_LAST  = (ACC_CYCLES == 2) ? CW'(2) : CW'(ACC_CYCLES - 1);

  arb_state_t      state_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   ptr_d;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic            we_q;
  sram_addr_t      addr_q;
  sram_data_t      wdata_q;
  sram_data_t      rdata_q;
  logic            io_oe_q;
  logic            ce_b_q, oe_b_q, we_b_q, ub_b_q, lb_b_q;

  logic [NREQ-1:0] rr_grant;
  logic [PW-1:0]   rr_idx;
  logic [NREQ-1:0] win_oh;
  logic [PW-1:0]   win_idx;
  logic            upd_ptr;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .grant (rr_grant),
    .gidx  (rr_idx)
  );

  always_comb begin
    win_oh  = rr_grant;
    win_idx = rr_idx;
    upd_ptr = 1'b1;
`ifdef SRAM_ARB_VGA_PRIO_EN
    if (req[0]) begin
      win_oh  = NREQ'(1);
      win_idx = '0;
      upd_ptr = 1'b0;
    end
`endif
  end

  assign ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
  assign cnt_d = cnt_q + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      io_oe_q <= 1'b0;
      ce_b_q  <= 1'b1;
      oe_b_q  <= 1'b1;
      we_b_q  <= 1'b1;
      ub_b_q  <= 1'b1;
      lb_b_q  <= 1'b1;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= ACCESS;
            cnt_q   <= CW'(1);
            grant_q <= win_oh;
            if (upd_ptr) ptr_q <= ptr_d;
            we_q    <= req_we[win_idx];
            addr_q  <= req_addr[win_idx];
            wdata_q <= req_wdata[win_idx];
            ce_b_q  <= 1'b0;
            oe_b_q  <= req_we[win_idx];
            we_b_q  <= 1'b1;
            ub_b_q  <= ~req_be[win_idx][1];
            lb_b_q  <= ~req_be[win_idx][0];
            io_oe_q <= req_we[win_idx];
          end
        end
        ACCESS: begin
          if (cnt_q == LAST) begin
            state_q <= DONE;
            ce_b_q  <= 1'b1;
            oe_b_q  <= 1'b1;
            we_b_q  <= 1'b1;
            ub_b_q  <= 1'b1;
            lb_b_q  <= 1'b1;
            io_oe_q <= 1'b0;
            done_q  <= grant_q;
            if (!we_q) rdata_q <= sram_io;
          end else begin
            cnt_q  <= cnt_d;
            // we_b pulse sits inside the data-driven window on both sides
            we_b_q <= ~(we_q && (cnt_d >= WE_FIRST) && (cnt_d <= WE_LAST));
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sram_io   = io_oe_q ? wdata_q : {DATA_W{1'bz}};
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign sram_addr = addr_q;
  assign sram_ce_b = ce_b_q;
  assign sram_oe_b = oe_b_q;
  assign sram_we_b = we_b_q;
  assign sram_ub_b = ub_b_q;
  assign sram_lb_b = lb_b_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural async SRAM on the pins.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int NREQ = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NREQ-1:0]             req;
  logic [NREQ-1:0]             req_we;
  logic [NREQ-1:0][ADDR_W-1:0] req_addr;
  logic [NREQ-1:0][DATA_W-1:0] req_wdata;
  logic [NREQ-1:0][1:0]        req_be;
  wire  [NREQ-1:0]             done;
  wire  [15:0]                 rdata;
  wire  [19:0]                 sram_addr;
  wire  [15:0]                 sram_io;
  wire                         ce_b, oe_b, we_b, ub_b, lb_b;

  int n_tests = 0;
  int n_fail  = 0;
  int viol    = 0;

  logic [15:0] mem     [256];
  logic [15:0] ref_mem [256];

  always #5 clk = ~clk;

  sram_arbiter #(.NREQ(NREQ), .ACC_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .done      (done),
    .rdata     (rdata),
    .sram_addr (sram_addr),
    .sram_io   (sram_io),
    .sram_ce_b (ce_b),
    .sram_oe_b (oe_b),
    .sram_we_b (we_b),
    .sram_ub_b (ub_b),
    .sram_lb_b (lb_b)
  );

  // Floating bus reads as all ones
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (sram_io[i]);
  end

  assign sram_io = (!ce_b && !oe_b && we_b) ? mem[sram_addr[7:0]] : 16'hzzzz;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
    mem[8'h12] = 16'hBEEF;
    forever begin
      @(negedge clk);
      if (!ce_b && !we_b) begin
        if (!ub_b) mem[sram_addr[7:0]][15:8] = sram_io[15:8];
        if (!lb_b) mem[sram_addr[7:0]][7:0]  = sram_io[7:0];
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ((!oe_b && !we_b) || ($countones(done) > 1))) viol <= viol + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int r, w, a, be, cyc, exp_idx;
    logic [15:0] d;
    logic got;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'hA000 | 16'(i);
    ref_mem[8'h12] = 16'hBEEF;

    #2 rst = 1'b1;
    tick();
    check("rst_done",    32'(done), 0);
    check("rst_rdata",   32'(rdata), 0);
    check("rst_addr",    32'(sram_addr), 0);
    check("rst_strobes", 32'({ce_b, oe_b, we_b, ub_b, lb_b}), 'h1F);
    check("rst_io",      32'(sram_io), 'hFFFF);
    @(negedge clk) rst = 1'b0;
    tick();

    // Single read by requester 1
    req_addr[1] = 20'h00012; req_we[1] = 1'b0; req_be[1] = 2'b11; req[1] = 1'b1;
    tick();
    check("rd_c1_ce",   32'(ce_b), 0);
    check("rd_c1_oe",   32'(oe_b), 0);
    check("rd_c1_addr", 32'(sram_addr), 'h12);
    check("rd_c1_done", 32'(done), 0);
    tick();
    check("rd_c2_oe",   32'(oe_b), 0);
    check("rd_c2_we",   32'(we_b), 1);
    check("rd_c2_done", 32'(done), 0);
    tick();
    check("rd_done",    32'(done), 'h2);
    check("rd_rdata",   32'(rdata), 'hBEEF);
    check("rd_dn_oe",   32'(oe_b), 1);
    check("rd_dn_ce",   32'(ce_b), 1);
    req[1] = 1'b0;
    tick();
    check("rd_idle_done",  32'(done), 0);
    check("rd_rdata_hold", 32'(rdata), 'hBEEF);

    // Single upper-byte write by requester 2
    req_addr[2] = 20'hFFFFF; req_wdata[2] = 16'h1234; req_be[2] = 2'b10; req_we[2] = 1'b1; req[2] = 1'b1;
    tick();
    check("wr_c1_strb", 32'({ce_b, oe_b, we_b, ub_b, lb_b}), 'b01101);
    check("wr_c1_io",   32'(sram_io), 'h1234);
    check("wr_c1_addr", 32'(sram_addr), 'hFFFFF);
    tick();
    check("wr_c2_we",   32'(we_b), 0);
    check("wr_c2_io",   32'(sram_io), 'h1234);
    tick();
    check("wr_done",    32'(done), 'h4);
    check("wr_dn_strb", 32'({ce_b, oe_b, we_b, ub_b, lb_b}), 'h1F);
    check("wr_dn_io",   32'(sram_io), 'hFFFF);
    check("wr_rdata",   32'(rdata), 'hBEEF);
    req[2] = 1'b0;
    ref_mem[8'hFF] = 16'h12FF;
    tick();
    check("wr_mem", 32'(mem[8'hFF]), 32'(ref_mem[8'hFF]));

    // Continuous contention from all three
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i] = 20'h20 + 20'(i); req_we[i] = 1'b0; req_be[i] = 2'b11;
    end
    req = 3'b111;
    for (int g = 0; g < 6; g++) begin
`ifdef SRAM_ARB_VGA_PRIO_EN
      exp_idx = 0;
`else
      exp_idx = g % 3;
`endif
      repeat ((g == 0) ? 2 : 3) begin
        tick();
        check("rr_gap", 32'(done), 0);
      end
      tick();
      check("rr_grant", 32'(done), 1 << exp_idx);
      check("rr_rdata", 32'(rdata), 32'(ref_mem[8'h20 + exp_idx]));
    end
    req = '0;
    tick();

    // Requester 0 drops req on its first access cycle
    req_addr[0] = 20'h50; req_addr[1] = 20'h51; req_we = '0;
    req = 3'b011;
    tick();
    req[0] = 1'b0;
    check("drop_c1", 32'(done), 0);
    tick();
    check("drop_c2", 32'(done), 0);
    tick();
    check("drop_done0", 32'(done), 'h1);
    check("drop_rdata0", 32'(rdata), 'hA050);
    repeat (3) begin
      tick();
      check("drop_gap", 32'(done), 0);
    end
    tick();
    check("drop_next1", 32'(done), 'h2);
    check("drop_rdata1", 32'(rdata), 'hA051);
    req = '0;
    tick();

    // Reset on the second access cycle of a write
    req_addr[1] = 20'h30; req_we[1] = 1'b1; req_wdata[1] = 16'h5555; req_be[1] = 2'b11;
    req = 3'b010;
    tick();
    check("abort_c1_ce", 32'(ce_b), 0);
    tick();
    check("abort_c2_we", 32'(we_b), 0);
    #1 rst = 1'b1;
    #1;
    check("abort_strobes", 32'({ce_b, oe_b, we_b, ub_b, lb_b}), 'h1F);
    check("abort_io",      32'(sram_io), 'hFFFF);
    check("abort_done",    32'(done), 0);
    req = '0;
    tick();
    check("abort_done2", 32'(done), 0);
    check("abort_mem",   32'(mem[8'h30]), 32'(ref_mem[8'h30]));
    @(negedge clk) rst = 1'b0;
    tick();
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i] = 20'h20 + 20'(i); req_we[i] = 1'b0; req_be[i] = 2'b11;
    end
    req = 3'b111;
    repeat (2) begin
      tick();
      check("post_rst_gap", 32'(done), 0);
    end
    tick();
    check("post_rst_ptr",   32'(done), 'h1);
    check("post_rst_rdata", 32'(rdata), 'hA020);
    req = '0;
    tick();

    // Random single-requester traffic against a reference memory
    for (int it = 0; it < 500; it++) begin
      r  = $urandom_range(0, NREQ - 1);
      w  = $urandom_range(0, 1);
      a  = 8'h40 + $urandom_range(0, 15);
      d  = 16'($urandom);
      be = $urandom_range(0, 3);
      req_addr[r] = 20'(a); req_we[r] = w[0]; req_wdata[r] = d; req_be[r] = be[1:0];
      req[r] = 1'b1;
      cyc = 0; got = 1'b0;
      while (!got && cyc < 20) begin
        tick();
        cyc++;
        if (done != '0) got = 1'b1;
      end
      check("rnd_timeout", 32'(got), 1);
      check("rnd_done",    32'(done), 1 << r);
      if (w == 0) check("rnd_rdata", 32'(rdata), 32'(ref_mem[a]));
      else begin
        if (be[1]) ref_mem[a][15:8] = d[15:8];
        if (be[0]) ref_mem[a][7:0]  = d[7:0];
      end
      req[r] = 1'b0;
    end
    tick();
    for (int i = 8'h40; i < 8'h50; i++) check("rnd_mem", 32'(mem[i]), 32'(ref_mem[i]));
    check("bus_hygiene", 32'(viol), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
